// File: rtl/vga_timing_pkg.sv
// Shared timing defaults (800x600@60), axis-total helper, bus typedefs and FSM state type.
// Optional frame counter in vga_timing_gen is enabled by VGA_TIMING_FRAME_CNT_EN.
package vga_timing_pkg;

  localparam int DEF_CNT_W    = 11;
  localparam int DEF_COLOR_W  = 12;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  typedef logic [DEF_CNT_W-1:0] vga_cnt_t;
  typedef logic [11:0]          vga_rgb_t;

  // IDLE: counters parked at origin, next pixel tick reloads (0,0) and fires both strobes.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vga_state_e;

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis: wrapping position counter with blank/sync decoded from the next count,
// so blank and sync change in the same cycle as the count they describe.
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int   CNT_W  = 11,
  parameter int   ACTIVE = 800,
  parameter int   FP     = 40,
  parameter int   SYNC   = 128,
  parameter int   BP     = 88,
  parameter logic POL    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             blnk,
  output logic             sync,
  output logic             wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [CNT_W-1:0] LAST_L   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACTIVE_L = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_S_L = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_E_L = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] cnt_nxt;

  assign wrap = (cnt == LAST_L);

  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (step) begin
      cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      blnk <= 1'b0;
      sync <= ~POL;
    end else begin
      cnt  <= cnt_nxt;
      blnk <= (cnt_nxt >= ACTIVE_L);
      sync <= (cnt_nxt >= SYNC_S_L && cnt_nxt < SYNC_E_L) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel-enable throttling, run enable and line/frame strobes.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CNT_W    = DEF_CNT_W,
  parameter int   COLOR_W  = DEF_COLOR_W,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               pix_en,
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               hblnk,
  output logic               vblnk,
  output logic [COLOR_W-1:0] rgb,
  output logic               line_start,
  output logic               frame_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [15:0]        frame_cnt,
`endif
  output logic               fsm_state
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W ||
      H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_param_check
    $fatal(1, "vga_timing_gen: timing does not fit CNT_W or has a zero-length field");
  end

  vga_state_e state;
  logic       tick;
  logic       h_step;
  logic       v_step;
  logic       h_wrap;
  logic       v_wrap;
  logic       line_hit;
  logic       frame_hit;

  // The first tick out of IDLE only reloads the origin, so the axes do not step on it.
  assign tick      = en & pix_en;
  assign h_step    = tick & (state == ST_RUN);
  assign v_step    = h_step & h_wrap;
  assign line_hit  = (state == ST_IDLE) | h_wrap;
  assign frame_hit = (state == ST_IDLE) | (h_wrap & v_wrap);

  vga_axis_cnt #(
    .CNT_W  (CNT_W),
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL)
  ) u_h_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (h_step),
    .clr   (~en),
    .cnt   (hcount),
    .blnk  (hblnk),
    .sync  (hsync),
    .wrap  (h_wrap)
  );

  vga_axis_cnt #(
    .CNT_W  (CNT_W),
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL)
  ) u_v_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (v_step),
    .clr   (~en),
    .cnt   (vcount),
    .blnk  (vblnk),
    .sync  (vsync),
    .wrap  (v_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (!en) begin
      state       <= ST_IDLE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      state       <= ST_RUN;
      line_start  <= line_hit;
      frame_start <= frame_hit;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (!en) begin
      frame_cnt <= '0;
    end else if (tick && frame_hit) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

  assign fsm_state = state;
  assign rgb       = '0;

endmodule
